// File: rtl/operand_seq_pkg.sv
// Shared types and beat-index constants for the operand sequencer.
// A frame is five beats: sel first, then operands a..d in order.
package operand_seq_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        EXEC    = 1'b1
    } state_t;

    localparam int FRAME_BEATS = 5;

    typedef logic [2:0] beat_t;

    localparam beat_t BEAT_SEL = 3'd0;
    localparam beat_t BEAT_A   = 3'd1;
    localparam beat_t BEAT_B   = 3'd2;
    localparam beat_t BEAT_C   = 3'd3;
    localparam beat_t BEAT_D   = 3'd4;

endpackage

// File: rtl/operand_seq_out_reg.sv
// Result capture register with a valid/ready output handshake.
// A load always wins; the sequencer only loads while the register is empty.
module operand_seq_out_reg #(
    parameter int DATA_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [DATA_W:0]     i_res1,
    input  logic [2*DATA_W-1:0] i_res2,
    input  logic [DATA_W-1:0]   i_res3,
    input  logic [1:0]          i_flags,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [DATA_W:0]     o_res1,
    output logic [2*DATA_W-1:0] o_res2,
    output logic [DATA_W-1:0]   o_res3,
    output logic [1:0]          o_flags
);

    logic                r_valid;
    logic [DATA_W:0]     r_res1;
    logic [2*DATA_W-1:0] r_res2;
    logic [DATA_W-1:0]   r_res3;
    logic [1:0]          r_flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_res1  <= '0;
            r_res2  <= '0;
            r_res3  <= '0;
            r_flags <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_res1  <= i_res1;
            r_res2  <= i_res2;
            r_res3  <= i_res3;
            r_flags <= i_flags;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_res1  = r_res1;
    assign o_res2  = r_res2;
    assign o_res3  = r_res3;
    assign o_flags = r_flags;

endmodule

// File: rtl/operand_sequencer.sv
// Serial nibble-stream front-end for the 4-operand combinational block:
// assembles a 5-beat frame, presents it for one EXEC cycle, captures results.
module operand_sequencer
    import operand_seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic [1:0]          op_sel,
    output logic [DATA_W-1:0]   op_a,
    output logic [DATA_W-1:0]   op_b,
    output logic [DATA_W-1:0]   op_c,
    output logic [DATA_W-1:0]   op_d,
    output logic                op_valid,
    input  logic [DATA_W:0]     res1_in,
    input  logic [2*DATA_W-1:0] res2_in,
    input  logic [DATA_W-1:0]   res3_in,
    input  logic [1:0]          flags_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W:0]     out_res1,
    output logic [2*DATA_W-1:0] out_res2,
    output logic [DATA_W-1:0]   out_res3,
    output logic [1:0]          out_flags,
    output logic                err_frame,
    output logic [CNT_W-1:0]    frame_count,
    output logic [CNT_W-1:0]    err_count
);

    state_t            r_state, w_state_nxt;
    beat_t             r_beat, w_beat_nxt;
    logic [1:0]        r_sel;
    logic [DATA_W-1:0] r_a, r_b, r_c, r_d;
    logic              r_err_frame;
    logic [CNT_W-1:0]  r_frame_count, r_err_count;
    logic              w_accept, w_last_ok, w_err, w_exec, w_out_valid;

    // Final beat is held off while unconsumed results still occupy the output.
    assign in_ready  = !rst && (r_state == COLLECT) &&
                       ((r_beat < BEAT_D) || !w_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign w_last_ok = (in_last == (r_beat == BEAT_D));
    assign w_exec    = (r_state == EXEC);
    assign op_valid  = !rst && w_exec;

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_err       = 1'b0;
        case (r_state)
            COLLECT: begin
                if (w_accept) begin
                    if (!w_last_ok) begin
                        w_beat_nxt = BEAT_SEL;
                        w_err      = 1'b1;
                    end else if (r_beat == BEAT_D) begin
                        w_beat_nxt  = BEAT_SEL;
                        w_state_nxt = EXEC;
                    end else begin
                        w_beat_nxt = r_beat + 3'd1;
                    end
                end
            end
            EXEC:    w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
            r_beat  <= BEAT_SEL;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    // Operand registers take each beat as it arrives, even if the frame is later dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_d   <= '0;
        end else if (w_accept) begin
            case (r_beat)
                BEAT_SEL: r_sel <= in_data[1:0];
                BEAT_A:   r_a   <= in_data;
                BEAT_B:   r_b   <= in_data;
                BEAT_C:   r_c   <= in_data;
                BEAT_D:   r_d   <= in_data;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_frame   <= 1'b0;
            r_err_count   <= '0;
            r_frame_count <= '0;
        end else begin
            r_err_frame <= w_err;
            if (w_err && (r_err_count != {CNT_W{1'b1}}))
                r_err_count <= r_err_count + CNT_W'(1);
            if (w_exec)
                r_frame_count <= r_frame_count + CNT_W'(1);
        end
    end

    operand_seq_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_exec),
        .i_res1  (res1_in),
        .i_res2  (res2_in),
        .i_res3  (res3_in),
        .i_flags (flags_in),
        .i_ready (out_ready),
        .o_valid (w_out_valid),
        .o_res1  (out_res1),
        .o_res2  (out_res2),
        .o_res3  (out_res3),
        .o_flags (out_flags)
    );

    assign out_valid   = w_out_valid;
    assign op_sel      = r_sel;
    assign op_a        = r_a;
    assign op_b        = r_b;
    assign op_c        = r_c;
    assign op_d        = r_d;
    assign err_frame   = r_err_frame;
    assign frame_count = r_frame_count;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: stand-in arithmetic block, queue-based frame
// model checked every cycle, plus directed literal checks and random traffic.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [3:0] in_data = '0;
    logic [1:0] op_sel;
    logic [3:0] op_a, op_b, op_c, op_d;
    logic       op_valid;
    logic [4:0] res1_in;
    logic [7:0] res2_in;
    logic [3:0] res3_in;
    logic [1:0] flags_in;
    logic       out_valid, out_ready = 1'b1;
    logic [4:0] out_res1;
    logic [7:0] out_res2;
    logic [3:0] out_res3;
    logic [1:0] out_flags;
    logic       err_frame;
    logic [7:0] frame_count, err_count;

    int n_cmp = 0;
    int n_err = 0;
    bit rnd_rdy = 1'b0;

    always #5 clk = ~clk;

    operand_sequencer #(.DATA_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .op_sel(op_sel),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d), .op_valid(op_valid),
        .res1_in(res1_in), .res2_in(res2_in), .res3_in(res3_in), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_res1(out_res1),
        .out_res2(out_res2), .out_res3(out_res3), .out_flags(out_flags),
        .err_frame(err_frame), .frame_count(frame_count), .err_count(err_count)
    );

    // Stand-in combinational block: sel[0]=0 -> a+b / c+d, sel[0]=1 -> c-d / ~b.
    function automatic logic [4:0] blk_r1(int s, int a, int b, int c, int d);
        return s[0] ? 5'(c - d) : 5'(a + b);
    endfunction
    function automatic logic [7:0] blk_r2(int a, int b, int c, int d);
        return 8'(a * b + c * d);
    endfunction
    function automatic logic [3:0] blk_r3(int s, int b, int c, int d);
        return s[0] ? 4'(~b) : 4'(c + d);
    endfunction
    function automatic logic [1:0] blk_fl(int a, int b, int c, int d);
        return {blk_r2(a, b, c, d) == 8'd0, c < d};
    endfunction

    always_comb begin
        res1_in  = blk_r1(int'(op_sel), int'(op_a), int'(op_b), int'(op_c), int'(op_d));
        res2_in  = blk_r2(int'(op_a), int'(op_b), int'(op_c), int'(op_d));
        res3_in  = blk_r3(int'(op_sel), int'(op_b), int'(op_c), int'(op_d));
        flags_in = blk_fl(int'(op_a), int'(op_b), int'(op_c), int'(op_d));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of beats collected so far plus the pending result.
    bit         chk_en = 1'b0;
    int         m_beats[$];
    int         m_fr[5];
    bit         m_exec = 1'b0, m_hold = 1'b0, m_errp = 1'b0;
    logic [4:0] m_r1 = '0;
    logic [7:0] m_r2 = '0;
    logic [3:0] m_r3 = '0;
    logic [1:0] m_fl = '0;
    int         m_frames = 0, m_errs = 0;

    always @(negedge clk) begin
        bit e_rdy, acc;
        int idx;
        e_rdy = !rst && !m_exec && (m_beats.size() < 4 || !m_hold || out_ready);
        if (chk_en) begin
            chk("in_ready", in_ready, e_rdy);
            chk("op_valid", op_valid, m_exec && !rst);
            if (m_exec && !rst) begin
                chk("op_sel", op_sel, m_fr[0]);
                chk("op_a", op_a, m_fr[1]);
                chk("op_b", op_b, m_fr[2]);
                chk("op_c", op_c, m_fr[3]);
                chk("op_d", op_d, m_fr[4]);
            end
            chk("out_valid", out_valid, m_hold);
            chk("out_res1", out_res1, m_r1);
            chk("out_res2", out_res2, m_r2);
            chk("out_res3", out_res3, m_r3);
            chk("out_flags", out_flags, m_fl);
            chk("err_frame", err_frame, m_errp);
            chk("frame_count", frame_count, m_frames);
            chk("err_count", err_count, m_errs);
        end
        if (rst) begin
            m_beats.delete();
            m_exec = 0; m_hold = 0; m_errp = 0;
            m_r1 = '0; m_r2 = '0; m_r3 = '0; m_fl = '0;
            m_frames = 0; m_errs = 0;
            chk_en = 1'b1;
        end else if (chk_en) begin
            acc = in_valid && e_rdy;
            m_errp = 0;
            if (m_hold && out_ready) m_hold = 0;
            if (m_exec) begin
                m_r1 = blk_r1(m_fr[0], m_fr[1], m_fr[2], m_fr[3], m_fr[4]);
                m_r2 = blk_r2(m_fr[1], m_fr[2], m_fr[3], m_fr[4]);
                m_r3 = blk_r3(m_fr[0], m_fr[2], m_fr[3], m_fr[4]);
                m_fl = blk_fl(m_fr[1], m_fr[2], m_fr[3], m_fr[4]);
                m_hold = 1;
                m_frames = (m_frames + 1) % 256;
                m_exec = 0;
            end
            if (acc) begin
                idx = m_beats.size();
                if (in_last == (idx == 4)) begin
                    m_beats.push_back(idx == 0 ? (int'(in_data) & 3) : int'(in_data));
                    if (m_beats.size() == 5) begin
                        for (int k = 0; k < 5; k++) m_fr[k] = m_beats[k];
                        m_beats.delete();
                        m_exec = 1;
                    end
                end else begin
                    m_beats.delete();
                    m_errp = 1;
                    if (m_errs < 255) m_errs++;
                end
            end
        end
    end

    // All stimulus tasks start and end 1 ns after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int data, input bit last);
        bit rdy = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'(data);
        in_last  = last;
        for (int w = 0; w < 200; w++) begin
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        if (!rdy) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: in_ready never rose, expected acceptance within 200 cycles");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int s, input int a, input int b, input int c, input int d);
        drive_beat(s, 0); drive_beat(a, 0); drive_beat(b, 0); drive_beat(c, 0); drive_beat(d, 1);
    endtask

    task automatic chk_res(input string nm, input int r1, input int r2, input int r3, input int fl);
        chk({nm, "_res1"}, out_res1, r1);
        chk({nm, "_res2"}, out_res2, r2);
        chk({nm, "_res3"}, out_res3, r3);
        chk({nm, "_flags"}, out_flags, fl);
    endtask

    initial begin
        int bad, badpos;
        bit lst;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_counts", {frame_count, err_count}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic frames with hand-computed results
        send_frame(0, 3, 5, 9, 2);
        idle(2);
        chk_res("frameA", 8, 33, 11, 0);
        chk("frameA_count", frame_count, 1);
        send_frame(1, 7, 2, 2, 9);
        idle(2);
        chk_res("frameB", 25, 32, 13, 1);
        chk("frameB_count", frame_count, 2);

        // Backpressure on the final beat
        out_ready = 1'b0;
        send_frame(0, 1, 2, 3, 4);
        idle(3);
        drive_beat(1, 0); drive_beat(4, 0); drive_beat(3, 0); drive_beat(1, 0);
        in_valid = 1'b1; in_data = 4'd5; in_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_blocked", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("bp_exec", op_valid, 1);
        chk("bp_consumed", out_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk_res("bp", 28, 17, 12, 1);
        @(posedge clk); #1;

        // Early in_last drops the frame
        drive_beat(0, 0); drive_beat(1, 0); drive_beat(2, 1);
        @(negedge clk);
        chk("mal_pulse", err_frame, 1);
        chk("mal_count", err_count, 1);
        chk("mal_no_exec", op_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mal_pulse_end", err_frame, 0);
        @(posedge clk); #1;
        send_frame(0, 3, 5, 9, 2);
        idle(2);
        chk_res("after_mal", 8, 33, 11, 0);

        // Error counter saturation
        repeat (256) drive_beat(0, 1);
        idle(1);
        chk("err_sat", err_count, 255);

        // Reset mid-frame discards partial frame and all state
        drive_beat(2, 0); drive_beat(1, 0); drive_beat(1, 0); drive_beat(1, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mid_counts", {frame_count, err_count}, 0);
        chk("rst_mid_valid", out_valid, 0);
        send_frame(0, 3, 5, 9, 2);
        idle(2);
        chk_res("rst_mid", 8, 33, 11, 0);
        chk("rst_mid_count", frame_count, 1);

        // Random traffic against the model
        rnd_rdy = 1'b1;
        for (int f = 0; f < 300; f++) begin
            bad = ($urandom % 10 == 0) ? 1 : 0;
            badpos = $urandom_range(0, 4);
            for (int i = 0; i < 5; i++) begin
                idle($urandom_range(0, 2));
                lst = (i == 4);
                if (bad != 0 && i == badpos) lst = !lst;
                drive_beat($urandom_range(0, 15), lst);
                if (bad != 0 && i == badpos) break;
            end
            if ($urandom % 50 == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
        end
        rnd_rdy = 1'b0;
        out_ready = 1'b1;
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
